dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl_pkg.sv | 24 ++
 rtl/dcache_ctrl_mshr_file.sv | 74 +++++++
 rtl/dcache_ctrl.sv | 130 +++++++++++++
 tb/tb_dcache_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the data-cache controller: memory command encoding and MSHR entry layout.
package dcache_ctrl_pkg;

  localparam int MEM_TAG_W = 4;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_cmd_e;

  typedef struct packed {
    logic                 vld;
    logic [63:0]          addr;
    logic [MEM_TAG_W-1:0] mem_tag;
    logic                 clobber;
  } mshr_entry_t;

  // Lines are 8 bytes, so two addresses name the same data when bits above the offset agree.
  function automatic logic same_line(input logic [63:0] a, input logic [63:0] b);
    return a[63:3] == b[63:3];
  endfunction

endpackage

// File: rtl/dcache_ctrl_mshr_file.sv
// Outstanding load-miss tracker: lowest-free allocation, address merge lookup, fill tag lookup.
// Lookups are combinational; entry state changes at the clock edge; full blocks new allocations.
module mshr_file
  import dcache_ctrl_pkg::*;
#(
  parameter int MSHR_NUM = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en,
  input  logic [63:0]          alloc_addr,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  logic [63:0]          look_addr,
  output logic                 look_hit,
  input  logic [MEM_TAG_W-1:0] fill_tag,
  output logic                 fill_hit,
  output logic [63:0]          fill_addr,
  output logic                 fill_clobber,
  input  logic                 st_en,
  input  logic [63:0]          st_addr,
  output logic                 full
);

  localparam int IW = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;

  mshr_entry_t ent [MSHR_NUM];

  logic [IW-1:0] fill_idx;
  logic [IW-1:0] free_idx;
  logic          free_found;

  always_comb begin
    look_hit     = 1'b0;
    fill_hit     = 1'b0;
    fill_addr    = '0;
    fill_clobber = 1'b0;
    fill_idx     = '0;
    free_idx     = '0;
    free_found   = 1'b0;
    full         = 1'b1;
    for (int i = 0; i < MSHR_NUM; i++) begin
      if (ent[i].vld && same_line(ent[i].addr, look_addr)) look_hit = 1'b1;
      if (!fill_hit && fill_tag != '0 && ent[i].vld && ent[i].mem_tag == fill_tag) begin
        fill_hit     = 1'b1;
        fill_idx     = IW'(i);
        fill_addr    = ent[i].addr;
        fill_clobber = ent[i].clobber;
      end
      if (!ent[i].vld) begin
        full = 1'b0;
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = IW'(i);
        end
      end
    end
  end

  // The allocation slot is always free, so it never collides with the slot a fill releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSHR_NUM; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < MSHR_NUM; i++) begin
        if (st_en && ent[i].vld && same_line(ent[i].addr, st_addr)) ent[i].clobber <= 1'b1;
        if (fill_hit && fill_idx == IW'(i)) ent[i].vld <= 1'b0;
        if (alloc_en && free_found && free_idx == IW'(i)) begin
          ent[i] <= '{vld: 1'b1, addr: alloc_addr, mem_tag: alloc_tag, clobber: 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through data cache with MSHR file and a single shared memory port.
// Hits answer in the request cycle; misses and stores are acked when memory accepts; full MSHR stalls loads.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int CACHE_LINES = 32,
  parameter int MSHR_NUM    = 4,
  parameter int MEM_TAG_W   = dcache_ctrl_pkg::MEM_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          lsq2Dcache_ld_addr_i,
  input  logic                 lsq2Dcache_ld_en_i,
  input  logic [63:0]          lsq2Dcache_st_addr_i,
  input  logic [63:0]          lsq2Dcache_st_data_i,
  input  logic                 lsq2Dcache_st_en_i,
  input  logic [MEM_TAG_W-1:0] mem2proc_response_i,
  input  logic [63:0]          mem2proc_data_i,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag_i,
  output logic                 Dcache_hit_o,
  output logic [63:0]          Dcache_data_o,
  output logic [63:0]          Dcache_mshr_addr_o,
  output logic                 Dcache_mshr_vld_o,
  output logic                 Dcache_mshr_ld_ack_o,
  output logic                 Dcache_mshr_st_ack_o,
  output logic                 Dcache_mshr_stall_o,
  output logic [1:0]           proc2mem_command_o,
  output logic [63:0]          proc2mem_addr_o,
  output logic [63:0]          proc2mem_data_o
);

  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int TAG_W = 61 - IDX_W;

  logic [CACHE_LINES-1:0] line_vld;
  logic [TAG_W-1:0]       line_tag  [CACHE_LINES];
  logic [63:0]            line_data [CACHE_LINES];

  logic [IDX_W-1:0] ld_idx, st_idx, f_idx;
  logic [TAG_W-1:0] ld_tag, st_tag, f_tag;

  logic        fill_hit, fill_clobber, mshr_match, mshr_full;
  logic [63:0] fill_addr;
  logic        resp_ok, ld_active, ld_hit, ld_miss, ld_merge, ld_issue;
  logic        alloc_en, st_owner, st_ack, fill_install, st_line_hit, st_wr;
  mem_cmd_e    cmd;

  assign ld_idx = lsq2Dcache_ld_addr_i[3 +: IDX_W];
  assign ld_tag = lsq2Dcache_ld_addr_i[63 -: TAG_W];
  assign st_idx = lsq2Dcache_st_addr_i[3 +: IDX_W];
  assign st_tag = lsq2Dcache_st_addr_i[63 -: TAG_W];
  assign f_idx  = fill_addr[3 +: IDX_W];
  assign f_tag  = fill_addr[63 -: TAG_W];

  mshr_file #(.MSHR_NUM(MSHR_NUM)) u_mshr (
    .clk          (clk),
    .rst          (rst),
    .alloc_en     (alloc_en),
    .alloc_addr   (lsq2Dcache_ld_addr_i),
    .alloc_tag    (mem2proc_response_i),
    .look_addr    (lsq2Dcache_ld_addr_i),
    .look_hit     (mshr_match),
    .fill_tag     (mem2proc_tag_i),
    .fill_hit     (fill_hit),
    .fill_addr    (fill_addr),
    .fill_clobber (fill_clobber),
    .st_en        (st_ack),
    .st_addr      (lsq2Dcache_st_addr_i),
    .full         (mshr_full)
  );

  // A fill owns the response path, so any load presented alongside it is ignored.
  assign resp_ok   = mem2proc_response_i != '0;
  assign ld_active = lsq2Dcache_ld_en_i && !fill_hit;
  assign ld_hit    = ld_active && line_vld[ld_idx] && line_tag[ld_idx] == ld_tag;
  assign ld_miss   = ld_active && !ld_hit;
  assign ld_merge  = ld_miss && mshr_match;
  assign ld_issue  = ld_miss && !mshr_match && !mshr_full;
  assign alloc_en  = ld_issue && resp_ok;
  assign st_owner  = !ld_issue && lsq2Dcache_st_en_i;
  assign st_ack    = st_owner && resp_ok;

  // A store landing on a line being filled this cycle still counts as a hit, so its data wins.
  assign fill_install = fill_hit && !fill_clobber;
  assign st_line_hit  = (line_vld[st_idx] && line_tag[st_idx] == st_tag) ||
                        (fill_install && f_idx == st_idx && f_tag == st_tag);
  assign st_wr        = st_ack && st_line_hit;

  always_comb begin
    cmd             = MEM_NONE;
    proc2mem_addr_o = '0;
    proc2mem_data_o = '0;
    if (ld_issue) begin
      cmd             = MEM_LOAD;
      proc2mem_addr_o = lsq2Dcache_ld_addr_i;
    end else if (st_owner) begin
      cmd             = MEM_STORE;
      proc2mem_addr_o = lsq2Dcache_st_addr_i;
      proc2mem_data_o = lsq2Dcache_st_data_i;
    end
  end

  always_comb begin
    Dcache_data_o = '0;
    if (fill_hit)    Dcache_data_o = mem2proc_data_i;
    else if (ld_hit) Dcache_data_o = line_data[ld_idx];
  end

  assign proc2mem_command_o   = cmd;
  assign Dcache_hit_o         = ld_hit;
  assign Dcache_mshr_vld_o    = fill_hit;
  assign Dcache_mshr_addr_o   = fill_hit ? fill_addr : '0;
  assign Dcache_mshr_ld_ack_o = ld_merge || alloc_en;
  assign Dcache_mshr_st_ack_o = st_ack;
  assign Dcache_mshr_stall_o  = mshr_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      line_vld <= '0;
    end else begin
      if (fill_install) begin
        line_vld[f_idx]  <= 1'b1;
        line_tag[f_idx]  <= f_tag;
        line_data[f_idx] <= mem2proc_data_i;
      end
      if (st_wr) line_data[st_idx] <= lsq2Dcache_st_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: inputs change just after posedge, outputs compared at negedge.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic [63:0] ld_addr, st_addr, st_data, mem_data;
  logic        ld_en, st_en;
  logic [3:0]  mem_resp, mem_tag;
  logic        hit, mshr_vld, ld_ack, st_ack, stall;
  logic [63:0] dout, mshr_addr, pm_addr, pm_data;
  logic [1:0]  pm_cmd;

  int errors = 0;
  int checks = 0;

  dcache_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .lsq2Dcache_ld_addr_i (ld_addr),
    .lsq2Dcache_ld_en_i   (ld_en),
    .lsq2Dcache_st_addr_i (st_addr),
    .lsq2Dcache_st_data_i (st_data),
    .lsq2Dcache_st_en_i   (st_en),
    .mem2proc_response_i  (mem_resp),
    .mem2proc_data_i      (mem_data),
    .mem2proc_tag_i       (mem_tag),
    .Dcache_hit_o         (hit),
    .Dcache_data_o        (dout),
    .Dcache_mshr_addr_o   (mshr_addr),
    .Dcache_mshr_vld_o    (mshr_vld),
    .Dcache_mshr_ld_ack_o (ld_ack),
    .Dcache_mshr_st_ack_o (st_ack),
    .Dcache_mshr_stall_o  (stall),
    .proc2mem_command_o   (pm_cmd),
    .proc2mem_addr_o      (pm_addr),
    .proc2mem_data_o      (pm_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic le, input logic [63:0] la, input logic se,
                       input logic [63:0] sa, input logic [63:0] sd,
                       input logic [3:0] rsp, input logic [3:0] ft, input logic [63:0] fd);
    ld_en = le; ld_addr = la; st_en = se; st_addr = sa; st_data = sd;
    mem_resp = rsp; mem_tag = ft; mem_data = fd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    @(negedge clk);
    checks++; if (pm_cmd !== 2'd0) begin errors++; $display("FAIL reset_cmd: got %0d expected 0", pm_cmd); end
    checks++; if ({hit, mshr_vld, ld_ack, st_ack, stall} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {hit, mshr_vld, ld_ack, st_ack, stall}); end
    checks++; if ({dout, mshr_addr, pm_addr, pm_data} !== 256'd0) begin errors++; $display("FAIL reset_buses: got nonzero %h expected 0", dout | mshr_addr | pm_addr | pm_data); end
    step();
    rst = 1'b0;
    drive(1, 64'h100, 0, 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL cold_hit: got %b expected 0", hit); end
    checks++; if (pm_cmd !== 2'd1) begin errors++; $display("FAIL cold_cmd: got %0d expected 1", pm_cmd); end
    checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL rejected_ack: got %b expected 0", ld_ack); end
    step();
  endtask

  task automatic test_miss_fill_hit();
    drive(1, 64'h200, 0, 0, 0, 4'd3, 0, 0);
    @(negedge clk);
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL miss_ack: got %b expected 1", ld_ack); end
    checks++; if (pm_cmd !== 2'd1 || pm_addr !== 64'h200) begin errors++; $display("FAIL miss_cmd: got %0d/%h expected 1/200", pm_cmd, pm_addr); end
    step();
    drive(0, 0, 0, 0, 0, 0, 4'd3, 64'hAB);
    @(negedge clk);
    checks++; if (mshr_vld !== 1'b1 || mshr_addr !== 64'h200) begin errors++; $display("FAIL fill_bcast: got %b/%h expected 1/200", mshr_vld, mshr_addr); end
    checks++; if (dout !== 64'hAB) begin errors++; $display("FAIL fill_data: got %h expected ab", dout); end
    step();
    drive(1, 64'h200, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (hit !== 1'b1 || dout !== 64'hAB) begin errors++; $display("FAIL hit_after_fill: got %b/%h expected 1/ab", hit, dout); end
    checks++; if (pm_cmd !== 2'd0) begin errors++; $display("FAIL hit_cmd: got %0d expected 0", pm_cmd); end
    step();
  endtask

  task automatic test_merge();
    drive(1, 64'h400, 0, 0, 0, 4'd2, 0, 0);
    step();
    drive(1, 64'h400, 0, 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    checks++; if (ld_ack !== 1'b1 || pm_cmd !== 2'd0) begin errors++; $display("FAIL merge: got ack=%b cmd=%0d expected ack=1 cmd=0", ld_ack, pm_cmd); end
    step();
    drive(1, 64'h400, 0, 0, 0, 0, 4'd2, 64'h44);
    @(negedge clk);
    checks++; if (mshr_vld !== 1'b1 || mshr_addr !== 64'h400) begin errors++; $display("FAIL merge_fill: got %b/%h expected 1/400", mshr_vld, mshr_addr); end
    checks++; if (ld_ack !== 1'b0 || hit !== 1'b0 || pm_cmd !== 2'd0) begin errors++; $display("FAIL fill_blocks_load: got ack=%b hit=%b cmd=%0d expected 0/0/0", ld_ack, hit, pm_cmd); end
    step();
    drive(0, 0, 0, 0, 0, 0, 4'd2, 64'h45);
    @(negedge clk);
    checks++; if (mshr_vld !== 1'b0) begin errors++; $display("FAIL stray_fill: got %b expected 0", mshr_vld); end
    step();
  endtask

  task automatic test_stall();
    logic [63:0] addrs [4];
    addrs = '{64'h1000, 64'h2008, 64'h3010, 64'h4018};
    for (int i = 0; i < 4; i++) begin
      drive(1, addrs[i], 0, 0, 0, 4'(i + 1), 0, 0);
      @(negedge clk);
      checks++; if (ld_ack !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL fill_up_%0d: got ack=%b stall=%b expected 1/0", i, ld_ack, stall); end
      step();
    end
    drive(1, 64'h5000, 0, 0, 0, 4'd6, 0, 0);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_rise: got %b expected 1", stall); end
    checks++; if (ld_ack !== 1'b0 || pm_cmd !== 2'd0) begin errors++; $display("FAIL full_load: got ack=%b cmd=%0d expected 0/0", ld_ack, pm_cmd); end
    step();
    drive(0, 0, 0, 0, 0, 0, 4'd2, 64'h22);
    @(negedge clk);
    checks++; if (mshr_vld !== 1'b1 || mshr_addr !== 64'h2008 || stall !== 1'b1) begin errors++; $display("FAIL free_fill: got vld=%b addr=%h stall=%b expected 1/2008/1", mshr_vld, mshr_addr, stall); end
    step();
    idle();
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_fall: got %b expected 0", stall); end
    step();
    for (int t = 1; t <= 4; t += 1) begin
      if (t == 2) continue;
      drive(0, 0, 0, 0, 0, 0, 4'(t), 64'h0);
      step();
    end
    idle();
  endtask

  task automatic test_store_arb();
    drive(1, 64'h300, 0, 0, 0, 4'd7, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 4'd7, 64'h33);
    step();
    drive(1, 64'h600, 1, 64'h300, 64'h5555, 4'd1, 0, 0);
    @(negedge clk);
    checks++; if (pm_cmd !== 2'd1 || pm_addr !== 64'h600) begin errors++; $display("FAIL arb_load_wins: got %0d/%h expected 1/600", pm_cmd, pm_addr); end
    checks++; if (ld_ack !== 1'b1 || st_ack !== 1'b0) begin errors++; $display("FAIL arb_acks: got ld=%b st=%b expected 1/0", ld_ack, st_ack); end
    step();
    drive(0, 0, 1, 64'h300, 64'h5555, 4'd5, 0, 0);
    @(negedge clk);
    checks++; if (pm_cmd !== 2'd2 || pm_addr !== 64'h300 || pm_data !== 64'h5555) begin errors++; $display("FAIL store_cmd: got %0d/%h/%h expected 2/300/5555", pm_cmd, pm_addr, pm_data); end
    checks++; if (st_ack !== 1'b1) begin errors++; $display("FAIL store_ack: got %b expected 1", st_ack); end
    step();
    drive(1, 64'h300, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (hit !== 1'b1 || dout !== 64'h5555) begin errors++; $display("FAIL write_through: got %b/%h expected 1/5555", hit, dout); end
    step();
    drive(0, 0, 0, 0, 0, 0, 4'd1, 64'h66);
    step();
    drive(1, 64'h200, 0, 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    checks++; if (hit !== 1'b0 || pm_cmd !== 2'd1 || ld_ack !== 1'b0) begin errors++; $display("FAIL conflict_evict: got hit=%b cmd=%0d ack=%b expected 0/1/0", hit, pm_cmd, ld_ack); end
    step();
  endtask

  task automatic test_clobber();
    drive(1, 64'h200, 0, 0, 0, 4'd9, 0, 0);
    step();
    drive(0, 0, 1, 64'h200, 64'h77, 4'd5, 0, 0);
    @(negedge clk);
    checks++; if (st_ack !== 1'b1 || pm_cmd !== 2'd2) begin errors++; $display("FAIL clob_store: got ack=%b cmd=%0d expected 1/2", st_ack, pm_cmd); end
    step();
    drive(0, 0, 0, 0, 0, 0, 4'd9, 64'h99);
    @(negedge clk);
    checks++; if (mshr_vld !== 1'b1 || mshr_addr !== 64'h200 || dout !== 64'h99) begin errors++; $display("FAIL clob_bcast: got %b/%h/%h expected 1/200/99", mshr_vld, mshr_addr, dout); end
    step();
    drive(1, 64'h200, 0, 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL clob_no_install: got %b expected 0", hit); end
    step();
    drive(1, 64'h600, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (hit !== 1'b1 || dout !== 64'h66) begin errors++; $display("FAIL clob_line_kept: got %b/%h expected 1/66", hit, dout); end
    step();
  endtask

  task automatic test_reset_mid();
    drive(1, 64'hA00, 0, 0, 0, 4'd4, 0, 0);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 4'd4, 64'hEE);
    @(negedge clk);
    checks++; if (mshr_vld !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL late_fill: got vld=%b stall=%b expected 0/0", mshr_vld, stall); end
    step();
    drive(1, 64'h600, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_clears_lines: got %b expected 0", hit); end
    step();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_miss_fill_hit();
    test_merge();
    test_stall();
    test_store_arb();
    test_clobber();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
